// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, length and overlap mode.
// Mealy match output, a registered copy of it, and a saturating match counter.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = 'b101,
    parameter int               DEF_LEN = 3,
    localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             d_i,
    input  logic             load_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             overlap_i,
    input  logic             clear_i,
    output logic             y_o,
    output logic             y_q_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q_q;

    logic [PAT_W-1:0] cand;
    logic [PAT_W-1:0] mask;
    logic             enough_bits;
    logic             match;

    // Candidate is the newest len_q bits with d_i as the last one; the mask trims it to len_q.
    always_comb begin
        cand = {hist_q[PAT_W-2:0], d_i};
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        enough_bits = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
        match = en_i && !load_i && !rst_i && enough_bits && ((cand & mask) == (pat_q & mask));
    end

    assign y_o = match;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            pat_d  = pattern_i;
            ovl_d  = overlap_i;
            hist_d = '0;
            fill_d = '0;
            if (len_i == '0) begin
                len_d = LEN_W'(1);
            end else if (len_i > LEN_W'(PAT_W)) begin
                len_d = LEN_W'(PAT_W);
            end else begin
                len_d = len_i;
            end
        end else if (en_i) begin
            hist_d = {hist_q[PAT_W-2:0], d_i};
            if (match && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(PAT_W)) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
        if (clear_i) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEF_PAT;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= 1'b1;
            cnt_q  <= '0;
            y_q_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            cnt_q  <= cnt_d;
            y_q_q  <= match;
        end
    end

    assign y_q_o       = y_q_q;
    assign match_cnt_o = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed and randomized bench for seq_detect_param; a queue-based reference model
// tracks the fresh bits usable for a match and predicts y_o, y_q_o and the counter.
module tb_seq_detect_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i, en_i, d_i, load_i, overlap_i, clear_i;
    logic [PAT_W-1:0] pattern_i;
    logic [LEN_W-1:0] len_i;
    logic             y_o, y_q_o;
    logic [CNT_W-1:0] match_cnt_o;

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W), .DEF_PAT('b101), .DEF_LEN(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .d_i(d_i), .load_i(load_i),
        .pattern_i(pattern_i), .len_i(len_i), .overlap_i(overlap_i), .clear_i(clear_i),
        .y_o(y_o), .y_q_o(y_q_o), .match_cnt_o(match_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    bit fresh[$];
    int m_pat, m_len, m_cnt, m_yq;
    bit m_ovl;

    task automatic chk(string tag, int obs, int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fresh.delete();
        m_pat = 'b101; m_len = 3; m_ovl = 1'b1; m_cnt = 0; m_yq = 0;
    endtask

    function automatic bit ref_match(bit en, bit d, bit ld);
        int v;
        if (!en || ld) return 1'b0;
        if (fresh.size() < m_len - 1) return 1'b0;
        v = d;
        for (int k = 1; k < m_len; k++) v += int'(fresh[fresh.size() - k]) << k;
        return v == (m_pat % (1 << m_len));
    endfunction

    // One clock cycle: check y_o mid-cycle, then y_q_o and counter after the edge.
    task automatic cycle(string tag, bit en, bit d, bit ld, bit clr);
        bit exp_y;
        int L;
        en_i = en; d_i = d; load_i = ld; clear_i = clr;
        #3;
        exp_y = ref_match(en, d, ld);
        chk({tag, ".y"}, int'(y_o), int'(exp_y));
        @(posedge clk_i); #1;
        if (ld) begin
            L = int'(len_i);
            if (L == 0) L = 1;
            if (L > PAT_W) L = PAT_W;
            m_len = L; m_pat = int'(pattern_i); m_ovl = overlap_i;
            fresh.delete();
        end else if (en) begin
            if (exp_y && !m_ovl) fresh.delete();
            else begin
                fresh.push_back(d);
                if (fresh.size() > PAT_W) void'(fresh.pop_front());
            end
        end
        if (clr) m_cnt = 0;
        else if (exp_y && m_cnt < CMAX) m_cnt++;
        m_yq = exp_y;
        chk({tag, ".yq"}, int'(y_q_o), m_yq);
        chk({tag, ".cnt"}, int'(match_cnt_o), m_cnt);
        en_i = 0; load_i = 0; clear_i = 0;
    endtask

    task automatic do_load(string tag, int pat, int len, bit ovl);
        pattern_i = PAT_W'(pat); len_i = LEN_W'(len); overlap_i = ovl;
        cycle(tag, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        bit s32[5];
        bit s34[7];
        bit s36[10];
        int hits;
        s32 = '{1, 0, 1, 0, 1};
        s34 = '{1, 1, 0, 1, 1, 0, 1};
        s36 = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1};
        en_i = 0; d_i = 0; load_i = 0; clear_i = 0; overlap_i = 0;
        pattern_i = '0; len_i = '0;
        rst_i = 1'b1;
        model_reset();
        #12;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst.yq", int'(y_q_o), 0);
        chk("rst.cnt", int'(match_cnt_o), 0);

        // Default overlapping 101 on 10101: hits on bits 3 and 5
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            cycle("ovl101", 1'b1, s32[i], 1'b0, 1'b0);
            hits += m_yq;
        end
        chk("ovl101.hits", hits, 2);
        chk("ovl101.cnt2", int'(match_cnt_o), 2);

        // Gap with en_i low must not disturb history
        cycle("gap.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("gap.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("gap.b0", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("gap.b1b", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("gap.final", m_yq, 1);

        // Reset between edges after partial 1,0; y_o gated during reset
        cycle("rstm.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("rstm.b0", 1'b1, 1'b0, 1'b0, 1'b0);
        en_i = 1; d_i = 1;
        #2 rst_i = 1'b1;
        #1;
        chk("rstm.y", int'(y_o), 0);
        chk("rstm.yq", int'(y_q_o), 0);
        chk("rstm.cnt", int'(match_cnt_o), 0);
        model_reset();
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        cycle("rstm.after", 1'b1, 1'b1, 1'b0, 1'b0);

        // Non-overlapping 101
        do_load("ld101", 'b101, 3, 1'b0);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            cycle("nov101", 1'b1, s32[i], 1'b0, 1'b0);
            hits += m_yq;
        end
        chk("nov101.hits", hits, 1);

        // Overlapping 1101 on 1101101: hits on bits 4 and 7
        do_load("ld1101", 'b1101, 4, 1'b1);
        cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        hits = 0;
        for (int i = 0; i < 7; i++) begin
            cycle("ovl1101", 1'b1, s34[i], 1'b0, 1'b0);
            hits += m_yq;
        end
        chk("ovl1101.hits", hits, 2);
        chk("ovl1101.cnt2", int'(match_cnt_o), 2);

        // Saturation: six matches with 2-bit counter, then clear wins over a 7th
        cycle("clr2", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 10; i++) cycle("sat", 1'b1, s36[i], 1'b0, 1'b0);
        chk("sat.cnt3", int'(match_cnt_o), 3);
        cycle("sat.b1", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("sat.b0", 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("sat.clrhit", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("sat.clrhit.y", m_yq, 1);
        chk("sat.clrhit.cnt0", int'(match_cnt_o), 0);

        // Length clamping: 0 -> 1 and 7 -> PAT_W
        do_load("ld.len0", 'b0001, 0, 1'b1);
        cycle("len1.a", 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("len1.b", 1'b1, 1'b0, 1'b0, 1'b0);
        do_load("ld.len7", 'b1001, 7, 1'b0);
        for (int i = 0; i < 8; i++) cycle("len4", 1'b1, (i % 3) == 0, 1'b0, 1'b0);

        // Randomized traffic with occasional reconfiguration and clear
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                pattern_i = PAT_W'($urandom);
                len_i = LEN_W'($urandom_range(0, 7));
                overlap_i = $urandom_range(0, 1);
                cycle("rnd.ld", $urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 1'b0);
            end else begin
                cycle("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 1), 1'b0,
                      $urandom_range(0, 19) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 4: maximum pattern length in bits (>=2).
REQ-002 Parameter CNT_W, default 8: match counter width.
REQ-003 Parameter DEF_PAT, default 'b101: reset-value pattern, zero-extended to PAT_W.
REQ-004 Parameter DEF_LEN, default 3: reset-value pattern length.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 en_i  input  1  d_i carries a valid serial bit this cycle.
REQ-008 d_i  input  1  serial data bit.
REQ-009 load_i  input  1  latch pattern_i/len_i/overlap_i as new configuration.
REQ-010 pattern_i  input  PAT_W  pattern; bit [len-1] is the first expected bit, bit [0] the last.
REQ-011 len_i  input  $clog2(PAT_W+1)  pattern length.
REQ-012 overlap_i  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-013 clear_i  input  1  synchronous clear of match counter.
REQ-014 y_o  output  1  Mealy match: combinational, high in the cycle the completing bit is presented.
REQ-015 y_q_o  output  1  y_o registered (one cycle later).
REQ-016 match_cnt_o  output  CNT_W  saturating count of matches.

Function
REQ-017 Internal state: history shift register hist[PAT_W-1:0], fill counter 0..PAT_W, config regs pat_r, len_r, ovl_r.
REQ-018 On en_i=1 and no load_i: hist <= {hist[PAT_W-2:0], d_i}; fill increments, saturating at PAT_W.
REQ-019 Match condition: en_i=1, load_i=0, fill >= len_r-1, and {hist[len_r-2:0], d_i} == pat_r[len_r-1:0]; for len_r=1 match is d_i == pat_r[0].
REQ-020 y_o SHALL equal the match condition; it depends combinationally on d_i and en_i.
REQ-021 en_i=0: hist, fill unchanged; y_o=0; d_i ignored.
REQ-022 Overlap (ovl_r=1): after a match fill updates per REQ-018, so the pattern suffix may start the next match.
REQ-023 Non-overlap (ovl_r=0): on a match fill <= 0; next match needs len_r fresh bits.
REQ-024 load_i=1: pat_r<=pattern_i, ovl_r<=overlap_i, len_r<=len_i clamped (0 -> 1, >PAT_W -> PAT_W); fill<=0; hist<=0; y_o=0 that cycle; an en_i bit in the same cycle is discarded.
REQ-025 Counter: increments by 1 on each match; holds at 2^CNT_W-1.
REQ-026 clear_i=1: counter <= 0 next edge; clear coincident with a match yields 0 (clear wins).
REQ-027 y_q_o <= y_o each edge.
REQ-028 Latency: y_o 0 cycles after completing bit; y_q_o and match_cnt_o reflect it after 1 edge.

Reset
REQ-029 rst_i=1 asynchronously forces: hist=0, fill=0, y_q_o=0, match_cnt_o=0, pat_r=DEF_PAT, len_r=DEF_LEN, ovl_r=1.
REQ-030 While rst_i=1, y_o=0 regardless of en_i/d_i; detection resumes on first rising edge after deassertion.
REQ-031 Reset mid-sequence discards partial history; no match may use pre-reset bits.

Verification
REQ-032 After reset, en_i=1, d_i stream 1,0,1,0,1 -> y_o high on bits 3 and 5; match_cnt_o=2.
REQ-033 load pattern 'b101 len 3 overlap 0, stream 1,0,1,0,1 -> y_o high on bit 3 only; match_cnt_o=1.
REQ-034 load pattern 'b1101 len 4 overlap 1, stream 1,1,0,1,1,0,1 -> y_o on bits 4 and 7; y_q_o one cycle later each; count 2.
REQ-035 Default config, stream 1, gap (en_i=0, d_i=0 for 3 cycles), 0, 1 -> single match on final bit; no output during gap.
REQ-036 CNT_W=2, six matches -> match_cnt_o saturates at 3; clear_i asserted with a 7th match -> match_cnt_o=0.
REQ-037 Default config, stream 1,0 then rst_i pulsed between edges -> y_q_o, match_cnt_o 0 immediately; next bit 1 gives no match.
